// File: rtl/field_frame_scheduler.sv
// field_frame_scheduler
//   Frame-level controller for the fluid simulation. It runs one simulation
//   step and then one line-drawing pass per display frame. It also arbitrates
//   the single field-RAM write port between the loader (A) and the step unit
//   (B) with a round-robin policy.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   run                    level, frame scheduling enable (sampled in IDLE)
//   frame_start            one-cycle pulse at start of vertical blank
//   a_req/a_addr/a_data    loader write request; a_gnt is its grant (comb)
//   b_req/b_addr/b_data    step-unit write request; b_gnt is its grant (comb)
//   field_we, field_addr_write, field_data_in   registered RAM write port
//   step_start / step_done pulse handshake with the step unit
//   draw_start / draw_done pulse handshake with draw_lines
//   busy                   high in every state except IDLE
//   frame_count            completed frames, wraps at 16 bits
//   overrun_count          frame_start pulses missed while busy, saturating
//
// Configuration
//   SCHED_OVERRUN_CNT_EN   when defined, builds the saturating overrun
//                          counter; otherwise overrun_count is tied to 0.
module field_frame_scheduler #(
  parameter int FIELD_SIZE  = 48,
  parameter int FIELD_ADDRW = 6,
  parameter int FIELD_DATAW = 96
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   frame_start,
  input  logic                   a_req,
  input  logic [FIELD_ADDRW-1:0] a_addr,
  input  logic [FIELD_DATAW-1:0] a_data,
  output logic                   a_gnt,
  input  logic                   b_req,
  input  logic [FIELD_ADDRW-1:0] b_addr,
  input  logic [FIELD_DATAW-1:0] b_data,
  output logic                   b_gnt,
  output logic                   field_we,
  output logic [FIELD_ADDRW-1:0] field_addr_write,
  output logic [FIELD_DATAW-1:0] field_data_in,
  output logic                   step_start,
  input  logic                   step_done,
  output logic                   draw_start,
  input  logic                   draw_done,
  output logic                   busy,
  output logic [15:0]            frame_count,
  output logic [7:0]             overrun_count
);

  // The address width must be able to reach every field cell.
  if (FIELD_SIZE > (1 << FIELD_ADDRW)) begin : g_bad_size
    $error("FIELD_ADDRW too narrow for FIELD_SIZE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DRAW = 2'd2
  } state_t;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   last_r;
  logic                   step_start_next_s;
  logic                   draw_start_next_s;
  logic                   frame_done_s;
  logic                   grant_ok_s;
  logic                   a_gnt_s;
  logic                   b_gnt_s;
  logic                   field_we_r;
  logic [FIELD_ADDRW-1:0] field_addr_r;
  logic [FIELD_DATAW-1:0] field_data_r;
  logic                   step_start_r;
  logic                   draw_start_r;
  logic [15:0]            frame_count_r;

  // Next-state and start-pulse decode for the frame sequencer.
  always_comb begin
    state_next_s      = state_r;
    step_start_next_s = 1'b0;
    draw_start_next_s = 1'b0;
    frame_done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_start && run) begin
          state_next_s      = STEP;
          step_start_next_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      STEP: begin
        if (step_done) begin
          state_next_s      = DRAW;
          draw_start_next_s = 1'b1;
        end else begin
          state_next_s = STEP;
        end
      end
      DRAW: begin
        if (draw_done) begin
          state_next_s = IDLE;
          frame_done_s = 1'b1;
        end else begin
          state_next_s = DRAW;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Round-robin grant: on a tie the requester not served last wins. Grants
  // are suppressed while draw_lines reads the field, and during reset.
  always_comb begin
    grant_ok_s = !rst && ((state_r == IDLE) || (state_r == STEP));
    a_gnt_s    = 1'b0;
    b_gnt_s    = 1'b0;
    if (grant_ok_s) begin
      a_gnt_s = a_req && (!b_req || (last_r == LAST_B));
      b_gnt_s = b_req && (!a_req || (last_r == LAST_A));
    end else begin
      a_gnt_s = 1'b0;
      b_gnt_s = 1'b0;
    end
  end

  // Sequencer state, start pulses, frame counter and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      last_r        <= LAST_B;
      step_start_r  <= 1'b0;
      draw_start_r  <= 1'b0;
      frame_count_r <= 16'd0;
      field_we_r    <= 1'b0;
      field_addr_r  <= {FIELD_ADDRW{1'b0}};
      field_data_r  <= {FIELD_DATAW{1'b0}};
    end else begin
      state_r      <= state_next_s;
      step_start_r <= step_start_next_s;
      draw_start_r <= draw_start_next_s;
      if (frame_done_s) begin
        frame_count_r <= frame_count_r + 16'd1;
      end
      field_we_r <= a_gnt_s || b_gnt_s;
      // Address/data only move on a grant; they are don't-care while we=0.
      if (a_gnt_s) begin
        last_r       <= LAST_A;
        field_addr_r <= a_addr;
        field_data_r <= a_data;
      end else if (b_gnt_s) begin
        last_r       <= LAST_B;
        field_addr_r <= b_addr;
        field_data_r <= b_data;
      end
    end
  end

`ifdef SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_r;

  // Count frame_start pulses that arrive while a frame is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r <= 8'd0;
    end else if (frame_start && (state_r != IDLE) && (overrun_r != 8'd255)) begin
      overrun_r <= overrun_r + 8'd1;
    end
  end

  assign overrun_count = overrun_r;
`else
  assign overrun_count = 8'd0;
`endif

  assign a_gnt            = a_gnt_s;
  assign b_gnt            = b_gnt_s;
  assign field_we         = field_we_r;
  assign field_addr_write = field_addr_r;
  assign field_data_in    = field_data_r;
  assign step_start       = step_start_r;
  assign draw_start       = draw_start_r;
  assign busy             = (state_r != IDLE);
  assign frame_count      = frame_count_r;

endmodule

// File: tb/tb_field_frame_scheduler.sv
module tb_field_frame_scheduler;
  localparam int AW = 6;
  localparam int DW = 96;
`ifdef SCHED_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, run, frame_start;
  logic          a_req, b_req, a_gnt, b_gnt;
  logic [AW-1:0] a_addr, b_addr, field_addr_write;
  logic [DW-1:0] a_data, b_data, field_data_in;
  logic          field_we, step_start, step_done, draw_start, draw_done, busy;
  logic [15:0]   frame_count;
  logic [7:0]    overrun_count;

  field_frame_scheduler #(.FIELD_SIZE(48), .FIELD_ADDRW(AW), .FIELD_DATAW(DW)) dut (
    .clk(clk), .rst(rst), .run(run), .frame_start(frame_start),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
    .field_we(field_we), .field_addr_write(field_addr_write),
    .field_data_in(field_data_in), .step_start(step_start),
    .step_done(step_done), .draw_start(draw_start), .draw_done(draw_done),
    .busy(busy), .frame_count(frame_count), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int cyc; int kind; } ev_t;   // kind 0 step_start, 1 draw_start
  wr_t wq[$];
  ev_t eq[$];
  wr_t w_m;
  ev_t e_m;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic exp_write(int c, logic [AW-1:0] ad, logic [DW-1:0] d);
    wr_t w;
    w.cyc = c; w.addr = ad; w.data = d;
    wq.push_back(w);
  endtask

  task automatic exp_event(int c, int k);
    ev_t e;
    e.cyc = c; e.kind = k;
    eq.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or pulse.
  always @(negedge clk) begin
    if (field_we === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", {96'd0, 26'd0, field_addr_write}, 128'hFFFF);
      end else begin
        w_m = wq.pop_front();
        chk("write_cycle", cyc, w_m.cyc);
        chk("write_addr", field_addr_write, w_m.addr);
        chk("write_data", field_data_in, w_m.data);
      end
    end
    if ((step_start === 1'b1) || (draw_start === 1'b1)) begin
      if (eq.size() == 0) begin
        chk("unexpected_start", {step_start, draw_start}, 2'b00);
      end else begin
        e_m = eq.pop_front();
        chk("start_cycle", cyc, e_m.cyc);
        chk("start_kind", {step_start, draw_start}, (e_m.kind == 0) ? 2'b10 : 2'b01);
      end
    end
  end

  int t0;

  initial begin
    rst = 1'b1; run = 1'b0; frame_start = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    step_done = 1'b0; draw_done = 1'b0;

    // Reset and idle
    ticks(3);
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", field_we, 1'b0);
    chk("rst_addr", field_addr_write, 6'd0);
    chk("rst_data", field_data_in, 96'd0);
    chk("rst_step", step_start, 1'b0);
    chk("rst_draw", draw_start, 1'b0);
    chk("rst_gnt", {a_gnt, b_gnt}, 2'b00);
    chk("rst_fc", frame_count, 16'd0);
    chk("rst_ovr", overrun_count, 8'd0);
    for (int i = 0; i < 3; i++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      chk("idle_norun_busy", busy, 1'b0);
      tick();
    end
    chk("idle_norun_ovr", overrun_count, 8'd0);
    step_done = 1'b1; tick(); step_done = 1'b0; tick();
    chk("stray_step_done_busy", busy, 1'b0);

    // Full frame, run dropped mid-frame
    run = 1'b1;
    t0 = cyc;
    frame_start = 1'b1; exp_event(t0 + 1, 0);
    tick(); frame_start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      chk("frame_busy", busy, 1'b1);
      if (c == 5) run = 1'b0;
      if (c == 10) begin step_done = 1'b1; exp_event(t0 + 11, 1); end
      if (c == 30) draw_done = 1'b1;
      tick();
      step_done = 1'b0; draw_done = 1'b0;
    end
    chk("frame_end_busy", busy, 1'b0);
    chk("frame_count_1", frame_count, 16'd1);
    tick();

    // Round-robin tie in IDLE: A, B, A, B
    a_req = 1'b1; a_addr = 6'd5;  a_data = 96'hA5A5_0000_1111_2222_3333_4444;
    b_req = 1'b1; b_addr = 6'd42; b_data = 96'h0B0B_5555_6666_7777_8888_9999;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a_gnt", a_gnt, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("rr_b_gnt", b_gnt, (i % 2 == 0) ? 1'b0 : 1'b1);
      if (i % 2 == 0) exp_write(cyc + 1, 6'd5, a_data);
      else            exp_write(cyc + 1, 6'd42, b_data);
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // Single requester, one write per cycle
    b_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_addr = 6'(i + 1); b_data = 96'(i + 100);
      #1;
      chk("single_b_gnt", b_gnt, 1'b1);
      exp_write(cyc + 1, 6'(i + 1), 96'(i + 100));
      tick();
    end
    b_req = 1'b0;
    ticks(2);

    // Draw lockout; grant in the step_done cycle still honoured
    run = 1'b1;
    t0 = cyc;
    frame_start = 1'b1; exp_event(t0 + 1, 0);
    tick(); frame_start = 1'b0; run = 1'b0;
    ticks(4);                                   // cyc = t0+5
    step_done = 1'b1; exp_event(t0 + 6, 1);
    b_req = 1'b1; b_addr = 6'd33; b_data = 96'hDEAD_BEEF;
    #1;
    chk("lock_stepdone_gnt", b_gnt, 1'b1);
    exp_write(cyc + 1, 6'd33, 96'hDEAD_BEEF);
    tick(); step_done = 1'b0;
    for (int c = 6; c <= 15; c++) begin
      chk("lock_b_gnt", b_gnt, 1'b0);
      if (c == 15) draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
    end
    chk("lock_after_gnt", b_gnt, 1'b1);
    chk("lock_busy", busy, 1'b0);
    chk("frame_count_2", frame_count, 16'd2);
    exp_write(cyc + 1, 6'd33, 96'hDEAD_BEEF);
    tick(); b_req = 1'b0;
    ticks(2);

    // Overrun: 3 pulses in STEP, then one coincident with draw_done
    run = 1'b1;
    t0 = cyc;
    frame_start = 1'b1; exp_event(t0 + 1, 0);
    tick(); frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    end
    chk("ovr_3", overrun_count, OVR_EN ? 8'd3 : 8'd0);
    step_done = 1'b1; exp_event(cyc + 1, 1);
    tick(); step_done = 1'b0;
    ticks(2);
    draw_done = 1'b1; frame_start = 1'b1;
    tick(); draw_done = 1'b0; frame_start = 1'b0;
    chk("coinc_busy", busy, 1'b0);
    chk("frame_count_3", frame_count, 16'd3);
    chk("ovr_4", overrun_count, OVR_EN ? 8'd4 : 8'd0);
    ticks(3);
    chk("coinc_no_restart", busy, 1'b0);

    // Saturation: 300 more pulses in STEP
    frame_start = 1'b1; exp_event(cyc + 1, 0);
    tick();
    ticks(300);
    frame_start = 1'b0;
    chk("ovr_sat", overrun_count, OVR_EN ? 8'd255 : 8'd0);

    // Reset mid-DRAW; a late draw_done is ignored
    step_done = 1'b1; exp_event(cyc + 1, 1);
    tick(); step_done = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_fc", frame_count, 16'd0);
    chk("mid_rst_ovr", overrun_count, 8'd0);
    draw_done = 1'b1; tick(); draw_done = 1'b0;
    chk("late_draw_done_fc", frame_count, 16'd0);
    chk("late_draw_done_busy", busy, 1'b0);
    ticks(3);

    chk("writes_outstanding", wq.size(), 0);
    chk("starts_outstanding", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
